mac_accumulator: RTL and testbench
==================================

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 32, accumulator width; must be even and >= 18.
REQ-002 SHALL have parameter LEN_W, default 8, width of the accumulation-length input.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port Mode  input  1  0 = one 16-bit product; 1 = two 8-bit lane products (Product[15:8], Product[7:0]).
REQ-006 SHALL have port Sign  input  1  1 = signed (two's complement) operands; 0 = unsigned.
REQ-007 SHALL have port Len  input  LEN_W  number of products per accumulation; 0 is treated as 1.
REQ-008 SHALL have port Product  input  16  product from the 8x8 multiplier.
REQ-009 SHALL have port In_valid  input  1  Product is valid this cycle.
REQ-010 SHALL have port In_ready  output  1  block accepts a product this cycle.
REQ-011 SHALL have port Acc_out  output  ACC_W  result; in Mode 1, upper half = lane 1 and lower half = lane 0, each ACC_W/2 bits wide.
REQ-012 SHALL have port Out_valid  output  1  Acc_out holds a completed result.
REQ-013 SHALL have port Out_ready  input  1  downstream accepts the result.
REQ-014 SHALL have port Overflow  output  1  saturation occurred during the current accumulation.

Function
REQ-015 A beat SHALL be accepted only in a cycle where In_valid=1 and In_ready=1.
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM, HOLD.
REQ-017 In IDLE: In_ready=1 and Out_valid=0.
REQ-018 In IDLE, on the first accepted beat the block SHALL:
- latch Mode, Sign and Len;
- clear Overflow;
- load the accumulator with the extended product;
- set count=1;
- go to HOLD if the effective Len is 1, else go to ACCUM.
REQ-019 In ACCUM: In_ready=1; each accepted beat adds the extended product and increments count; when count reaches Len the block goes to HOLD.
REQ-020 In HOLD: Out_valid=1, In_ready=0, and Acc_out and Overflow are held stable; Out_ready=1 SHALL move the block to IDLE on the next cycle.
REQ-021 There SHALL be no IDLE bypass: In_ready is 0 in the cycle Out_valid is 1.
REQ-022 Latency: Out_valid SHALL rise on the cycle after the last accepted beat.
REQ-023 Changes to Mode, Sign or Len after the first beat SHALL be ignored until the next IDLE.
REQ-024 Operand extension:
- Sign=1: sign-extend the 16-bit product (Mode 0) or each 8-bit lane (Mode 1);
- Sign=0: zero-extend.
REQ-025 Each addition SHALL saturate on overflow:
- signed: clamp to the signed max/min of the lane width;
- unsigned: clamp to all-ones.
REQ-026 Any saturation SHALL set Overflow, and Overflow SHALL stay set until the next accumulation starts.
REQ-027 In Mode 1 the two lanes SHALL saturate independently, with no carry crossing between lanes.
REQ-028 In_valid=0 in ACCUM SHALL stall the block indefinitely without changing state.

Reset
REQ-029 rst=1 SHALL, on the next clock edge, force:
- state = IDLE;
- accumulator = 0, count = 0;
- Acc_out = 0, Out_valid = 0, Overflow = 0;
- In_ready = 1 from the first cycle after rst deasserts.
REQ-030 rst SHALL override every in-progress accumulation and any held result in any state; partial sums are discarded.

Structure
REQ-031 Shared package mac_pkg SHALL hold:
- the state enum (IDLE, ACCUM, HOLD);
- the default ACC_W constant;
- the Mode encoding constants.
REQ-032 Sub-module sat_adder (parameterised width, signed/unsigned select, sum and sat outputs) SHALL implement the saturating add.
REQ-033 sat_adder is instanced once per lane: in Mode 0 the two lane adders are chained as one full-width adder.

Verification
REQ-034 Signed sum: Sign=1, Mode=0, Len=3, products 0xFFFF, 0x0002, 0x0003 -> Acc_out=0x00000004 and Out_valid=1 on the cycle after beat 3; Overflow=0.
REQ-035 Unsigned sum: Sign=0, Mode=0, Len=2, products 0xFFFF, 0x0001 -> Acc_out=0x00010000.
REQ-036 Dual-lane signed: Sign=1, Mode=1, Len=2, products 0x8001, 0xFF02 -> Acc_out=0xFF7F0003 (lane1 = -129, lane0 = 3).
REQ-037 Saturation with ACC_W=20: Sign=1, Mode=0, Len=17, all products 0x7FFF -> Acc_out=0x7FFFF and Overflow=1.
REQ-038 Backpressure and reset:
- In HOLD, Out_ready=0 for 5 cycles with In_valid=1 -> Acc_out stable, In_ready=0, no beat accepted;
- rst asserted after 2 of 4 beats -> all outputs 0 and In_ready=1 after release.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator: FSM states, default width,
// and the Mode input encoding.
package mac_pkg;

  localparam int ACC_W_DEFAULT = 32;

  // Mode input encoding
  localparam logic MODE_WIDE = 1'b0;  // one 16-bit product, full-width sum
  localparam logic MODE_DUAL = 1'b1;  // two independent 8-bit lane products

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

endpackage

// File: rtl/mac_accumulator_sat_adder.sv
// Saturating adder slice. With i_sat_en low it behaves as a plain adder
// (carry-in honoured), so two slices can be chained into one wide adder
// where only the top slice decides saturation.
module sat_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  input  logic         i_signed,
  input  logic         i_sat_en,
  output logic [W-1:0] o_sum,
  output logic         o_sat
);

  logic [W:0] w_raw;
  logic       w_ovf;

  assign w_raw = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};

  // Overflow detection and clamp selection for this slice
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    o_sum = w_raw[W-1:0];
    w_ovf = 1'b0;
    if (i_signed) begin
      w_ovf = (i_a[W-1] == i_b[W-1]) && (w_raw[W-1] != i_a[W-1]);
    end else begin
      w_ovf = w_raw[W];
    end
    o_sat = i_sat_en & w_ovf;
    if (o_sat) begin
      // Signed overflow only happens when both operands share a sign,
      // so the sign of i_a picks max or min.
      o_sum = i_signed ? {i_a[W-1], {(W-1){~i_a[W-1]}}} : {W{1'b1}};
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Multiply-accumulate back end: sums a run of Len products from an 8x8
// multiplier, either as one wide value or as two independent lanes, with
// per-addition saturation and a sticky Overflow flag.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Mode,
  input  logic             Sign,
  input  logic [LEN_W-1:0] Len,
  input  logic [15:0]      Product,
  input  logic             In_valid,
  output logic             In_ready,
  output logic [ACC_W-1:0] Acc_out,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic             Overflow
);

  localparam int H = ACC_W / 2;

  state_t           r_state;
  logic             r_mode;
  logic             r_sign;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_mode;
  logic             w_sign;
  logic [LEN_W-1:0] w_len_eff;
  logic [LEN_W-1:0] w_count_nxt;
  logic [ACC_W-1:0] w_ext16;
  logic [H-1:0]     w_ext_hi8;
  logic [H-1:0]     w_ext_lo8;
  logic [ACC_W-1:0] w_operand;
  logic [ACC_W-1:0] w_base;
  logic [H-1:0]     w_lo_sum;
  logic [H-1:0]     w_hi_sum;
  logic [H-1:0]     w_lo_final;
  logic             w_lo_sat;
  logic             w_hi_sat;
  logic             w_lo_cout;
  logic             w_wide;
  logic [ACC_W-1:0] w_next_acc;
  logic             w_sat;

  assign w_accept    = In_valid & r_in_ready;
  // The first beat uses the live controls; later beats use the latched copy.
  assign w_mode      = (r_state == IDLE) ? Mode : r_mode;
  assign w_sign      = (r_state == IDLE) ? Sign : r_sign;
  assign w_wide      = (w_mode == MODE_WIDE);
  assign w_len_eff   = (Len == '0) ? LEN_W'(1) : Len;
  assign w_count_nxt = r_count + LEN_W'(1);

  assign w_ext16   = {{(ACC_W-16){w_sign & Product[15]}}, Product};
  assign w_ext_hi8 = {{(H-8){w_sign & Product[15]}}, Product[15:8]};
  assign w_ext_lo8 = {{(H-8){w_sign & Product[7]}}, Product[7:0]};
  assign w_operand = w_wide ? w_ext16 : {w_ext_hi8, w_ext_lo8};

  // Starting from zero on the first beat makes "load" the same path as "add".
  assign w_base = (r_state == IDLE) ? '0 : r_acc;

  sat_adder #(.W(H)) u_lane0 (
    .i_a      (w_base[H-1:0]),
    .i_b      (w_operand[H-1:0]),
    .i_cin    (1'b0),
    .i_signed (w_sign),
    .i_sat_en (~w_wide),
    .o_sum    (w_lo_sum),
    .o_sat    (w_lo_sat)
  );

  // Unsaturated lower sum wrapped below its addend exactly when it carried out.
  assign w_lo_cout = (w_lo_sum < w_base[H-1:0]);

  sat_adder #(.W(H)) u_lane1 (
    .i_a      (w_base[ACC_W-1:H]),
    .i_b      (w_operand[ACC_W-1:H]),
    .i_cin    (w_wide & w_lo_cout),
    .i_signed (w_sign),
    .i_sat_en (1'b1),
    .o_sum    (w_hi_sum),
    .o_sat    (w_hi_sat)
  );

  // In wide mode a clamp in the upper slice must also fill the lower slice.
  assign w_lo_final = (w_wide && w_hi_sat)
                    ? (w_sign ? {H{~w_base[ACC_W-1]}} : {H{1'b1}})
                    : w_lo_sum;
  assign w_next_acc = {w_hi_sum, w_lo_final};
  assign w_sat      = w_hi_sat | w_lo_sat;

  // Control FSM, accumulator and registered handshake outputs
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state     <= IDLE;
      r_mode      <= MODE_WIDE;
      r_sign      <= 1'b0;
      r_len       <= '0;
      r_count     <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mode  <= Mode;
            r_sign  <= Sign;
            r_len   <= w_len_eff;
            r_acc   <= w_next_acc;
            r_ovf   <= 1'b0;
            r_count <= LEN_W'(1);
            if (w_len_eff == LEN_W'(1)) begin
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_next_acc;
            r_ovf   <= r_ovf | w_sat;
            r_count <= w_count_nxt;
            if (w_count_nxt == r_len) begin
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (Out_ready) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign In_ready  = r_in_ready;
  assign Out_valid = r_out_valid;
  assign Acc_out   = r_acc;
  assign Overflow  = r_ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a 32-bit instance for the main
// function and a 20-bit instance for saturation corners.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        Mode;
  logic        Sign;
  logic [7:0]  Len;
  logic [15:0] Product;
  logic        v32;
  logic        v20;
  logic        Out_ready;

  logic        ir32, ov32, of32;
  logic [31:0] acc32;
  logic        ir20, ov20, of20;
  logic [19:0] acc20;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.ACC_W(32), .LEN_W(8)) u_dut32 (
    .clk(clk), .rst(rst), .Mode(Mode), .Sign(Sign), .Len(Len),
    .Product(Product), .In_valid(v32), .In_ready(ir32), .Acc_out(acc32),
    .Out_valid(ov32), .Out_ready(Out_ready), .Overflow(of32)
  );

  mac_accumulator #(.ACC_W(20), .LEN_W(8)) u_dut20 (
    .clk(clk), .rst(rst), .Mode(Mode), .Sign(Sign), .Len(Len),
    .Product(Product), .In_valid(v20), .In_ready(ir20), .Acc_out(acc20),
    .Out_valid(ov20), .Out_ready(Out_ready), .Overflow(of20)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat32(input logic [15:0] p);
    Product = p; v32 = 1'b1; tick(); v32 = 1'b0;
  endtask

  task automatic beat20(input logic [15:0] p);
    Product = p; v20 = 1'b1; tick(); v20 = 1'b0;
  endtask

  task automatic release_result();
    Out_ready = 1'b1; tick(); Out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (ir32 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ir32); end
    checks++; if (acc32 !== 32'h0) begin errors++; $display("FAIL reset_acc got %h want 0", acc32); end
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov32); end
    checks++; if (of32 !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", of32); end
    checks++; if (acc20 !== 20'h0 || ir20 !== 1'b1) begin errors++; $display("FAIL reset_dut20 acc %h rdy %b want 0/1", acc20, ir20); end
  endtask

  task automatic test_signed_sum();
    Mode = 1'b0; Sign = 1'b1; Len = 8'd3;
    beat32(16'hFFFF);
    beat32(16'h0002);
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL signed_early_valid got %b want 0", ov32); end
    beat32(16'h0003);
    checks++; if (ov32 !== 1'b1) begin errors++; $display("FAIL signed_latency got %b want 1", ov32); end
    checks++; if (acc32 !== 32'h0000_0004) begin errors++; $display("FAIL signed_sum got %h want 00000004", acc32); end
    checks++; if (of32 !== 1'b0) begin errors++; $display("FAIL signed_overflow got %b want 0", of32); end
    checks++; if (ir32 !== 1'b0) begin errors++; $display("FAIL signed_hold_ready got %b want 0", ir32); end
    release_result();
    checks++; if (ir32 !== 1'b1 || ov32 !== 1'b0) begin errors++; $display("FAIL signed_release rdy %b vld %b want 1/0", ir32, ov32); end
  endtask

  // Controls changed after the first beat must not affect the result.
  task automatic test_unsigned_sum();
    Mode = 1'b0; Sign = 1'b0; Len = 8'd2;
    beat32(16'hFFFF);
    Mode = 1'b1; Sign = 1'b1; Len = 8'd5;
    beat32(16'h0001);
    checks++; if (ov32 !== 1'b1) begin errors++; $display("FAIL unsigned_valid got %b want 1", ov32); end
    checks++; if (acc32 !== 32'h0001_0000) begin errors++; $display("FAIL unsigned_sum got %h want 00010000", acc32); end
    release_result();
  endtask

  task automatic test_dual_lane();
    Mode = 1'b1; Sign = 1'b1; Len = 8'd2;
    beat32(16'h8001);
    beat32(16'hFF02);
    checks++; if (acc32 !== 32'hFF7F_0003) begin errors++; $display("FAIL dual_sum got %h want ff7f0003", acc32); end
    checks++; if (of32 !== 1'b0 || ov32 !== 1'b1) begin errors++; $display("FAIL dual_flags ovf %b vld %b want 0/1", of32, ov32); end
    release_result();
  endtask

  task automatic test_len_zero();
    Mode = 1'b0; Sign = 1'b0; Len = 8'd0;
    beat32(16'h0005);
    checks++; if (ov32 !== 1'b1 || acc32 !== 32'h5) begin errors++; $display("FAIL len_zero vld %b acc %h want 1/00000005", ov32, acc32); end
    release_result();
  endtask

  task automatic test_stall();
    Mode = 1'b0; Sign = 1'b1; Len = 8'd2;
    beat32(16'h0010);
    for (int i = 0; i < 4; i++) tick();
    checks++; if (ir32 !== 1'b1 || ov32 !== 1'b0) begin errors++; $display("FAIL stall_state rdy %b vld %b want 1/0", ir32, ov32); end
    beat32(16'h0020);
    checks++; if (ov32 !== 1'b1 || acc32 !== 32'h30) begin errors++; $display("FAIL stall_sum vld %b acc %h want 1/00000030", ov32, acc32); end
    release_result();
  endtask

  task automatic test_backpressure();
    Mode = 1'b0; Sign = 1'b0; Len = 8'd1;
    beat32(16'h1234);
    Product = 16'hAAAA; v32 = 1'b1; Out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (acc32 !== 32'h1234) begin errors++; $display("FAIL bp_acc_%0d got %h want 00001234", i, acc32); end
      checks++; if (ir32 !== 1'b0 || ov32 !== 1'b1) begin errors++; $display("FAIL bp_hs_%0d rdy %b vld %b want 0/1", i, ir32, ov32); end
    end
    v32 = 1'b0;
    release_result();
    checks++; if (ir32 !== 1'b1 || ov32 !== 1'b0 || acc32 !== 32'h1234) begin errors++; $display("FAIL bp_release rdy %b vld %b acc %h want 1/0/00001234", ir32, ov32, acc32); end
  endtask

  task automatic test_sat_wide20();
    Mode = 1'b0; Sign = 1'b1; Len = 8'd17;
    for (int i = 0; i < 16; i++) beat20(16'h7FFF);
    checks++; if (acc20 !== 20'h7FFF0 || of20 !== 1'b0) begin errors++; $display("FAIL sat_pos_pre acc %h ovf %b want 7fff0/0", acc20, of20); end
    beat20(16'h7FFF);
    checks++; if (acc20 !== 20'h7FFFF) begin errors++; $display("FAIL sat_pos got %h want 7ffff", acc20); end
    checks++; if (of20 !== 1'b1 || ov20 !== 1'b1) begin errors++; $display("FAIL sat_pos_flags ovf %b vld %b want 1/1", of20, ov20); end
    release_result();
    for (int i = 0; i < 17; i++) beat20(16'h8000);
    checks++; if (acc20 !== 20'h80000 || of20 !== 1'b1) begin errors++; $display("FAIL sat_neg acc %h ovf %b want 80000/1", acc20, of20); end
    release_result();
    Sign = 1'b0;
    beat20(16'hFFFF);
    checks++; if (of20 !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b want 0", of20); end
    for (int i = 0; i < 16; i++) beat20(16'hFFFF);
    checks++; if (acc20 !== 20'hFFFFF || of20 !== 1'b1) begin errors++; $display("FAIL sat_unsigned acc %h ovf %b want fffff/1", acc20, of20); end
    release_result();
  endtask

  // Lanes clamp independently; last beat does not saturate, flag stays set.
  task automatic test_sat_dual20();
    Mode = 1'b1; Sign = 1'b1; Len = 8'd6;
    for (int i = 0; i < 5; i++) beat20(16'h7F80);
    checks++; if (acc20 !== 20'h7FE00) begin errors++; $display("FAIL dual_sat got %h want 7fe00", acc20); end
    beat20(16'h0001);
    checks++; if (acc20 !== 20'h7FE01 || of20 !== 1'b1 || ov20 !== 1'b1) begin errors++; $display("FAIL dual_sticky acc %h ovf %b vld %b want 7fe01/1/1", acc20, of20, ov20); end
    release_result();
  endtask

  task automatic test_reset_mid();
    Mode = 1'b0; Sign = 1'b0; Len = 8'd4;
    beat32(16'h0100);
    beat32(16'h0200);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (acc32 !== 32'h0 || ov32 !== 1'b0 || of32 !== 1'b0) begin errors++; $display("FAIL mid_reset acc %h vld %b ovf %b want 0/0/0", acc32, ov32, of32); end
    checks++; if (ir32 !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b want 1", ir32); end
    Len = 8'd1;
    beat32(16'h0007);
    checks++; if (acc32 !== 32'h7 || ov32 !== 1'b1) begin errors++; $display("FAIL post_reset acc %h vld %b want 00000007/1", acc32, ov32); end
    release_result();
  endtask

  initial begin
    rst = 1'b1; Mode = 1'b0; Sign = 1'b0; Len = 8'd1; Product = 16'h0;
    v32 = 1'b0; v20 = 1'b0; Out_ready = 1'b0;
    test_reset();
    test_signed_sum();
    test_unsigned_sum();
    test_dual_lane();
    test_len_zero();
    test_stall();
    test_backpressure();
    test_sat_wide20();
    test_sat_dual20();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
